mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage load/store controller between the EX/MEM pipeline register and the data-memory bus. It turns a pipeline load or store into one req/ack bus transaction with byte enables and stalls the pipeline until the access completes. Load data is aligned and sign/zero-extended, then registered as `data_mem_read`, which feeds the write-back mux.

## Interface
Parameters:
- `DATA_WIDTH`, 32 (from `my_pkg`), data and bus width; byte-lane logic is fixed at 4 lanes.
- `ADDR_WIDTH`, 32, byte address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_read`  in  1  load instruction in MEM stage.
- `mem_write`  in  1  store instruction in MEM stage.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_WIDTH  byte address (ALU result).
- `store_data`  in  DATA_WIDTH  rs2 value.
- `mem_stall`  out  1  freeze the pipeline.
- `data_mem_read`  out  DATA_WIDTH  extended load result, registered.
- `load_done`  out  1  one-cycle pulse when `data_mem_read` is updated.
- `misalign_err`  out  1  one-cycle misaligned-access pulse; present only with `MISALIGN_TRAP_EN`.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_WIDTH  word-aligned address, with `[1:0]` = 00.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  DATA_WIDTH  lane-placed store data.
- `dmem_ack`  in  1  transfer complete; read data is valid in the same cycle.
- `dmem_rdata`  in  DATA_WIDTH  read word.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Start condition: `start = (mem_read | mem_write)` while in IDLE.
  - If `mem_read` and `mem_write` are both high, the access is a load.
  - A load with `funct3` 011, 110 or 111, or a store with `funct3` >= 011, is performed as a word access.
- IDLE → BUSY on `start`, when the access is aligned or `MISALIGN_TRAP_EN` is undefined.
  - Register `dmem_we`, `dmem_addr` (= `addr` with `[1:0]` cleared), `dmem_be` and `dmem_wdata`.
  - Register the offset `addr[1:0]` and `funct3`.
- BUSY: hold `dmem_req`=1 with all bus outputs stable until `dmem_ack`.
  - On `dmem_ack`: deassert `dmem_req` at the next edge and go to DONE.
  - For a load, also capture the extended result into `data_mem_read`.
- DONE: lasts one cycle, then → IDLE.
  - Inputs are ignored in DONE, because the same instruction is still presented.
  - `load_done`=1 in DONE if the access was a load.
- Store lane placement:
  - SB: `dmem_be` = 0001 << off; data = byte replicated ×4.
  - SH: `dmem_be` = 0011 << (off[1]·2); data = half replicated ×2.
  - SW: `dmem_be` = 1111.
- Load extraction:
  - Select byte `off` or half `off[1]` from `dmem_rdata`.
  - B/H are sign-extended; BU/HU are zero-extended.
- `data_mem_read` holds its value until the next load completes; stores never change it.
- `mem_stall` = (IDLE & start & ~trap) | BUSY. It is combinational and low in DONE.
- Reset (asynchronous, any state) forces state IDLE and all outputs to 0.
  - `dmem_req` drops immediately; an in-flight transfer is abandoned.

## Timing
- Best case (`dmem_ack` in the first BUSY cycle), start in cycle 0:
  - Cycle 0: start accepted in IDLE.
  - Cycle 1: BUSY with `dmem_req` high; `dmem_ack` arrives.
  - Cycle 2: DONE; `data_mem_read` is valid.
  - `mem_stall` is high in cycles 0–1, giving 2 stall cycles.
- Each wait cycle without `dmem_ack` adds one stall cycle.
- Back-to-back accesses: the next start is accepted in the IDLE cycle after DONE, so the minimum spacing is 3 cycles.
- `dmem_ack` outside BUSY is ignored.

## Configuration
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned access (H/HU/SH with `addr[0]`=1; W/SW with `addr[1:0]`≠0) pulses `misalign_err` for one cycle.
  - No bus request is issued, `mem_stall` stays 0, and `data_mem_read` is unchanged.
  - The FSM stays in IDLE.
- Undefined:
  - The `misalign_err` port is absent.
  - Low address bits are forced aligned to the access size (half: `off[0]`=0; word: off=00) and the access proceeds normally.

## Test plan
- Reset: hold `rst_n`=0 in BUSY with `dmem_req`=1 → `dmem_req`, `mem_stall`, `data_mem_read` = 0 immediately; state is IDLE after release.
- LB, `addr`=0x1003, `dmem_rdata`=0x80FF_1234, ack on the first BUSY cycle:
  - `dmem_addr`=0x1000, `dmem_be`=1111 on the read.
  - `data_mem_read`=0xFFFF_FF80 in DONE; `load_done` pulses; 2 stall cycles.
- LHU, `addr`=0x2002, rdata 0xBEEF_0000, ack after 3 wait cycles → `data_mem_read`=0x0000_BEEF; `mem_stall` high for 5 cycles.
- SB, `addr`=0x3001, `store_data`=0x1234_56AB → `dmem_we`=1, `dmem_be`=0010, `dmem_wdata`=0xABAB_ABAB; `data_mem_read` unchanged.
- SH, `addr`=0x4002, `store_data`=0x0000_CAFE → `dmem_be`=1100, `dmem_wdata`=0xCAFE_CAFE; bus outputs stable across 2 wait cycles.
- LW, `addr`=0x5002:
  - With `MISALIGN_TRAP_EN`: `misalign_err` pulses once, no `dmem_req`, `mem_stall`=0.
  - Without it: `dmem_addr`=0x5000 and a normal word load.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl_if
//  Purpose  : Data-memory bus bundle between the MEM-stage load/store
//             controller (master) and the data memory (slave).
//  Signals  : dmem_req   - bus request, held until dmem_ack
//             dmem_we    - 1 = write, 0 = read
//             dmem_addr  - word-aligned byte address ([1:0] = 00)
//             dmem_be    - byte enables, one per lane (4 lanes)
//             dmem_wdata - lane-placed store data
//             dmem_ack   - transfer complete; read data valid same cycle
//             dmem_rdata - read word
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage load/store controller. Converts a pipeline load or
//             store into a single req/ack data-memory transaction with byte
//             enables, stalls the pipeline while the access is outstanding,
//             and returns the aligned, sign/zero-extended load result as a
//             registered value for write-back.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             mem_read, mem_write - load / store in MEM stage (both = load)
//             funct3              - 000 B, 001 H, 010 W, 100 BU, 101 HU
//             addr, store_data    - byte address and rs2 value
//             mem_stall           - freeze pipeline (combinational)
//             data_mem_read       - extended load result (registered)
//             load_done           - one-cycle pulse when data_mem_read updates
//             misalign_err        - misaligned-access pulse (MISALIGN_TRAP_EN)
//             bus                 - data-memory bus, master side
//  Config   : MISALIGN_TRAP_EN - when defined, misaligned accesses raise
//             misalign_err and issue no bus cycle; when undefined, the low
//             address bits are forced aligned to the access size.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  mem_read,
    input  wire logic                  mem_write,
    input  wire logic [2:0]            funct3,
    input  wire logic [ADDR_WIDTH-1:0] addr,
    input  wire logic [DATA_WIDTH-1:0] store_data,
    output logic                       mem_stall,
    output logic [DATA_WIDTH-1:0]      data_mem_read,
    output logic                       load_done,
`ifdef MISALIGN_TRAP_EN
    output logic                       misalign_err,
`endif
    mem_access_ctrl_if.master          bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                state_q,         state_d;
    logic                  dmem_req_q,      dmem_req_d;
    logic                  dmem_we_q,       dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q,     dmem_addr_d;
    logic [3:0]            dmem_be_q,       dmem_be_d;
    logic [DATA_WIDTH-1:0] dmem_wdata_q,    dmem_wdata_d;
    logic [1:0]            off_q,           off_d;
    logic [2:0]            funct3_q,        funct3_d;
    logic                  is_load_q,       is_load_d;
    logic [DATA_WIDTH-1:0] data_mem_read_q, data_mem_read_d;
    logic                  load_done_q,     load_done_d;
`ifdef MISALIGN_TRAP_EN
    logic                  misalign_err_q,  misalign_err_d;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  start;
    logic                  size_b;
    logic                  size_h;
    logic                  size_w;
    logic                  trap;
    logic [1:0]            off_eff;
    logic [3:0]            be_store;
    logic [DATA_WIDTH-1:0] wdata_store;

    assign start = mem_read | mem_write;

    // Loads decode BU/HU as well; every other encoding (and any store
    // funct3 above 010) degenerates to a word access.
    always_comb begin
        size_b = (funct3 == 3'b000) || (mem_read && (funct3 == 3'b100));
        size_h = (funct3 == 3'b001) || (mem_read && (funct3 == 3'b101));
        size_w = !size_b && !size_h;
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (size_h & addr[0]) | (size_w & (|addr[1:0]));
    assign trap       = misaligned;
`else
    assign trap       = 1'b0;
`endif

    // Offset actually used for lane selection: forced aligned to the
    // access size so an untrapped misaligned access still hits whole lanes.
    always_comb begin
        off_eff = addr[1:0];
        if (size_w) begin
            off_eff = 2'b00;
        end else if (size_h) begin
            off_eff = {addr[1], 1'b0};
        end
    end

    // Store lane placement: data is replicated across lanes so the byte
    // enables alone decide which lane the memory writes.
    always_comb begin
        be_store    = 4'b1111;
        wdata_store = store_data;
        if (size_b) begin
            be_store    = 4'b0001 << off_eff;
            wdata_store = {(DATA_WIDTH/8){store_data[7:0]}};
        end else if (size_h) begin
            be_store    = 4'b0011 << {off_eff[1], 1'b0};
            wdata_store = {(DATA_WIDTH/16){store_data[15:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the returned word
    // ------------------------------------------------------------------
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus.dmem_rdata[7:0];
            2'd1:    byte_sel = bus.dmem_rdata[15:8];
            2'd2:    byte_sel = bus.dmem_rdata[23:16];
            default: byte_sel = bus.dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}},   byte_sel};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},          byte_sel};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}},         half_sel};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_be_d       = dmem_be_q;
        dmem_wdata_d    = dmem_wdata_q;
        off_d           = off_q;
        funct3_d        = funct3_q;
        is_load_d       = is_load_q;
        data_mem_read_d = data_mem_read_q;
        load_done_d     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_err_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef MISALIGN_TRAP_EN
                misalign_err_d = start & misaligned;
`endif
                if (start && !trap) begin
                    state_d      = ST_BUSY;
                    dmem_req_d   = 1'b1;
                    // A simultaneous read and write is treated as a load.
                    dmem_we_d    = !mem_read;
                    dmem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    dmem_be_d    = mem_read ? 4'b1111 : be_store;
                    dmem_wdata_d = mem_read ? '0 : wdata_store;
                    off_d        = off_eff;
                    funct3_d     = funct3;
                    is_load_d    = mem_read;
                end
            end

            ST_BUSY: begin
                if (bus.dmem_ack) begin
                    state_d    = ST_DONE;
                    dmem_req_d = 1'b0;
                    if (is_load_q) begin
                        data_mem_read_d = load_ext;
                        load_done_d     = 1'b1;
                    end
                end
            end

            // The instruction is still presented here, so inputs are
            // deliberately ignored for one cycle.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_be_q       <= 4'b0000;
            dmem_wdata_q    <= '0;
            off_q           <= 2'b00;
            funct3_q        <= 3'b000;
            is_load_q       <= 1'b0;
            data_mem_read_q <= '0;
            load_done_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_err_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_be_q       <= dmem_be_d;
            dmem_wdata_q    <= dmem_wdata_d;
            off_q           <= off_d;
            funct3_q        <= funct3_d;
            is_load_q       <= is_load_d;
            data_mem_read_q <= data_mem_read_d;
            load_done_q     <= load_done_d;
`ifdef MISALIGN_TRAP_EN
            misalign_err_q  <= misalign_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated by rst_n so the stall drops immediately while reset is held,
    // even if the pipeline still presents a memory instruction.
    assign mem_stall = rst_n &
                       (((state_q == ST_IDLE) & start & ~trap) |
                        (state_q == ST_BUSY));

    assign data_mem_read  = data_mem_read_q;
    assign load_done      = load_done_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err   = misalign_err_q;
`endif

    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_wdata = dmem_wdata_q;

endmodule
`default_nettype wire
